// File: rtl/alu_pkg.sv
// Shared ALU command types and scheduler state encoding.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int CMD_W = 12;

    // Opcodes this scheduler cares about; the ALU defines the remaining codes.
    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b011,
        CAS = 3'b111
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [2:0] addr1;
        logic [2:0] addr2;
        logic [2:0] addr3;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } sched_state_t;

    // Only compare-and-swap produces a meaningful compare flag.
    function automatic logic is_cas(input op_t op);
        return (op == CAS);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester from a valid mask, starting at ptr and wrapping.
// Latency: purely combinational, grant in the same cycle as valid.
// Backpressure: none; with lock_en only requesters in lock_mask are eligible.
//  valid     : requesters with a pending command
//  ptr       : highest-priority index this cycle
//  lock_en   : restrict eligibility to lock_mask
//  lock_mask : one-hot lock owner
//  grant     : one-hot winner, grant_idx its index, grant_vld any winner
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    input  logic          lock_en,
    input  logic [N-1:0]  lock_mask,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [N-1:0] elig;
    int           pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = 0;
        elig      = lock_en ? (valid & lock_mask) : valid;
        // Scan ptr, ptr+1, ... with wrap; the first eligible requester wins.
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!grant_vld && elig[pos[IW-1:0]]) begin
                grant_vld             = 1'b1;
                grant[pos[IW-1:0]]    = 1'b1;
                grant_idx             = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_cmd_scheduler.sv
// Shares one ALU among N_REQ requesters: round-robin accept, start pulse, wait done, respond.
// Latency: accept c0, alu_start c1, earliest done c2, rsp_valid c3; one command per 4 cycles.
// Backpressure: response held until rsp_ready; no new accept or start while waiting on it.
//  req_valid/req_lock/req_cmd/req_ready : requester side, req_ready is the accept pulse
//  alu_cmd/alu_start/alu_done/alu_result/alu_cas_ok : ALU side
//  rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_cas_ok/rsp_timeout : response side
//  busy : scheduler not idle
module alu_cmd_scheduler
    import alu_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ*CMD_W-1:0]   req_cmd,
    output logic [N_REQ-1:0]         req_ready,
    output logic [CMD_W-1:0]         alu_cmd,
    output logic                     alu_start,
    input  logic                     alu_done,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     alu_cas_ok,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]        rsp_result,
    output logic                     rsp_cas_ok,
    output logic                     rsp_timeout,
    output logic                     busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    sched_state_t      state_q, state_d;
    alu_cmd_t          cmd_q, cmd_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   lock_owner_q, lock_owner_d;
    logic              lock_q, lock_d;
    logic              lock_valid_q, lock_valid_d;
    logic              cas_q, cas_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  lock_mask;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_vld;
    logic [CMD_W-1:0]  cmd_sel;
    logic [N_REQ-1:0]  ready_c;

    always_comb begin
        lock_mask               = '0;
        lock_mask[lock_owner_q] = 1'b1;
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .lock_en   (lock_valid_q),
        .lock_mask (lock_mask),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        cmd_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                cmd_sel = req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        lock_d       = lock_q;
        lock_valid_d = lock_valid_q;
        cas_d        = cas_q;
        timeout_d    = timeout_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        ready_c      = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    ready_c = grant;
                    cmd_d   = alu_cmd_t'(cmd_sel);
                    id_d    = grant_idx;
                    lock_d  = req_lock[grant_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    result_d  = alu_result;
                    cas_d     = alu_cas_ok && is_cas(cmd_q.op);
                    timeout_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abort: a hung ALU must not keep a lock owner pinned.
                    result_d     = '0;
                    cas_d        = 1'b0;
                    timeout_d    = 1'b1;
                    lock_valid_d = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d      = ST_IDLE;
                    rr_ptr_d     = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    lock_valid_d = lock_q && !timeout_q;
                    lock_owner_d = id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            id_q         <= '0;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            lock_q       <= 1'b0;
            lock_valid_q <= 1'b0;
            cas_q        <= 1'b0;
            timeout_q    <= 1'b0;
            result_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            id_q         <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            lock_q       <= lock_d;
            lock_valid_q <= lock_valid_d;
            cas_q        <= cas_d;
            timeout_q    <= timeout_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
        end
    end

    // The accept pulse is combinational from req_valid, so it is masked while
    // rst is high to keep every output at zero during reset.
    assign req_ready   = rst ? '0 : ready_c;
    assign alu_start   = (state_q == ST_ISSUE);
    assign alu_cmd     = (state_q == ST_ISSUE || state_q == ST_WAIT) ? cmd_q : '0;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = rsp_valid ? id_q : '0;
    assign rsp_result  = rsp_valid ? result_q : '0;
    assign rsp_cas_ok  = rsp_valid && cas_q;
    assign rsp_timeout = rsp_valid && timeout_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Directed bench for alu_cmd_scheduler with a one-cycle-latency ALU responder.
// Latency: checks exact accept/start/response cycle positions and the timeout length.
// Backpressure: exercises held responses, lock hold and reset in flight.
module tb_alu_cmd_scheduler;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_lock;
    logic [N*12-1:0] req_cmd;
    logic [N-1:0]  req_ready;
    logic [11:0]   alu_cmd;
    logic          alu_start;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic          alu_cas_ok;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [DW-1:0] rsp_result;
    logic          rsp_cas_ok;
    logic          rsp_timeout;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int last_wait;
    logic respond;
    logic cas_in;
    logic pend_on;

    alu_cmd_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_cmd(req_cmd), .req_ready(req_ready), .alu_cmd(alu_cmd),
        .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
        .alu_cas_ok(alu_cas_ok), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_cas_ok(rsp_cas_ok),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: done one cycle after the start cycle, result = cmd[7:0] ^ 8'h55.
    initial begin
        alu_done = 1'b0; alu_result = '0; alu_cas_ok = 1'b0; pend_on = 1'b0;
        forever begin
            @(posedge clk); #1;
            alu_done = 1'b0; alu_result = '0; alu_cas_ok = 1'b0;
            if (rst) begin
                pend_on = 1'b0;
            end else if (pend_on) begin
                alu_done   = 1'b1;
                alu_result = alu_cmd[7:0] ^ 8'h55;
                alu_cas_ok = cas_in;
                pend_on    = 1'b0;
            end
            if (alu_start && respond && !rst) pend_on = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  id;
        logic [11:0] cmd;
        logic        cas_in;
        logic [7:0]  exp_res;
        logic        exp_cas;
    } vec_t;

    vec_t        tbl[5];
    logic [11:0] rr_cmds[4];
    int          order[5];

    task automatic step();
        @(posedge clk); #3;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] rsp_vec();
        return {rsp_valid, rsp_id, rsp_result, rsp_cas_ok, rsp_timeout};
    endfunction

    function automatic logic [30:0] all_out();
        return {req_ready, alu_cmd, alu_start, rsp_valid, rsp_id, rsp_result,
                rsp_cas_ok, rsp_timeout, busy};
    endfunction

    task automatic set_cmd(input int id, input logic [11:0] c);
        req_cmd[id*12 +: 12] = c;
    endtask

    task automatic wait_ready(input string nm, input logic [3:0] exp);
        last_wait = 0;
        #1;
        while (req_ready == '0 && last_wait < 30) begin
            step();
            last_wait++;
        end
        chk(nm, req_ready, exp);
    endtask

    task automatic wait_rsp(input string nm);
        int n = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
        end
        chk(nm, rsp_valid, 1);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2'd0, 12'h050, 1'b0, 8'h05, 1'b0};
        tbl[1] = '{2'd1, 12'h2E5, 1'b1, 8'hB0, 1'b0};
        tbl[2] = '{2'd2, 12'h7C6, 1'b1, 8'h93, 1'b0};
        tbl[3] = '{2'd3, 12'hE53, 1'b1, 8'h06, 1'b1};
        tbl[4] = '{2'd0, 12'hFAC, 1'b0, 8'hF9, 1'b0};
        rr_cmds = '{12'h111, 12'h222, 12'h333, 12'h444};
        order   = '{0, 1, 2, 3, 0};

        rst = 1'b1; req_valid = 4'b1111; req_lock = '0; req_cmd = '0;
        rsp_ready = 1'b0; respond = 1'b1; cas_in = 1'b0;
        step();
        chk("reset outputs", all_out(), 31'd0);
        rst = 1'b0; req_valid = '0;
        step();
        chk("idle after reset", {busy, req_ready}, 5'd0);

        // Round-robin with every requester valid and rsp_ready held high.
        req_cmd = {rr_cmds[3], rr_cmds[2], rr_cmds[1], rr_cmds[0]};
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ready($sformatf("rr grant %0d", k), 4'b0001 << order[k]);
            if (k > 0) chk($sformatf("rr throughput %0d", k), last_wait, 0);
            step();
            if (k == 4) req_valid = '0;
            chk($sformatf("rr start %0d", k), {alu_start, alu_cmd}, {1'b1, rr_cmds[order[k]]});
            step();
            chk($sformatf("rr start width %0d", k), alu_start, 0);
            wait_rsp($sformatf("rr rsp %0d", k));
            chk($sformatf("rr rsp id %0d", k), rsp_id, order[k]);
            step();
        end

        // Single-requester transactions with exact cycle positions.
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b0001 << tbl[i].id;
            set_cmd(tbl[i].id, tbl[i].cmd);
            cas_in = tbl[i].cas_in;
            wait_ready($sformatf("tbl%0d ready", i), 4'b0001 << tbl[i].id);
            step();
            req_valid = '0;
            chk($sformatf("tbl%0d issue", i), {alu_start, alu_cmd, req_ready},
                {1'b1, tbl[i].cmd, 4'b0});
            step();
            chk($sformatf("tbl%0d wait", i), {alu_start, rsp_valid}, 2'b00);
            step();
            chk($sformatf("tbl%0d rsp", i), rsp_vec(),
                {1'b1, tbl[i].id, tbl[i].exp_res, tbl[i].exp_cas, 1'b0});
            step();
            chk($sformatf("tbl%0d idle", i), {busy, rsp_valid}, 2'b00);
        end

        // Lock: req1 keeps the ALU over a waiting req2, even with req_valid dropped.
        do_reset();
        rsp_ready = 1'b0; cas_in = 1'b1;
        set_cmd(1, 12'hE53); set_cmd(2, 12'h7C6);
        req_lock = 4'b0010; req_valid = 4'b0110;
        wait_ready("lock first grant", 4'b0010);
        step();
        set_cmd(1, 12'h2E5); req_lock = '0; req_valid = 4'b0100;
        chk("lock cmd sampled at accept", {alu_start, alu_cmd}, {1'b1, 12'hE53});
        wait_rsp("lock rsp1");
        chk("lock rsp1 fields", rsp_vec(), {1'b1, 2'd1, 8'h06, 1'b1, 1'b0});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lock blocks req2 %0d", c), {busy, req_ready}, 5'd0);
            step();
        end
        req_valid = 4'b0110;
        wait_ready("lock owner regrant", 4'b0010);
        step();
        req_valid = 4'b0100;
        chk("lock cmd2", alu_cmd, 12'h2E5);
        wait_rsp("lock rsp2");
        chk("lock rsp2 fields", rsp_vec(), {1'b1, 2'd1, 8'hB0, 1'b0, 1'b0});
        rsp_ready = 1'b1;
        step();
        wait_ready("lock released req2", 4'b0100);
        step();
        req_valid = '0;
        wait_rsp("req2 rsp");
        chk("req2 rsp fields", rsp_vec(), {1'b1, 2'd2, 8'h93, 1'b0, 1'b0});
        step();
        rsp_ready = 1'b0;

        // Timeout with a silent ALU; the lock request must be discarded.
        respond = 1'b0;
        set_cmd(0, 12'hE53); req_lock = 4'b0001; req_valid = 4'b0001;
        wait_ready("to grant", 4'b0001);
        step();
        req_valid = '0; req_lock = '0;
        chk("to start", alu_start, 1);
        last_wait = 0;
        step();
        while (!rsp_valid && last_wait < 40) begin
            last_wait++;
            step();
        end
        chk("to wait cycles", last_wait, TO);
        chk("to rsp fields", rsp_vec(), {1'b1, 2'd0, 8'h00, 1'b0, 1'b1});
        alu_done = 1'b1; alu_result = 8'hFF; alu_cas_ok = 1'b1;
        step();
        chk("to late done in resp", rsp_vec(), {1'b1, 2'd0, 8'h00, 1'b0, 1'b1});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        alu_done = 1'b1; alu_result = 8'hFF;
        step();
        chk("to late done in idle", {busy, alu_start, rsp_valid}, 3'b000);
        respond = 1'b1;
        req_valid = 4'b0010;
        wait_ready("to lock cleared", 4'b0010);
        step();
        req_valid = '0;
        wait_rsp("to next rsp");
        chk("to next rsp fields", rsp_vec(), {1'b1, 2'd1, 8'hB0, 1'b0, 1'b0});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Backpressure: response held 10 cycles while req2 waits.
        cas_in = 1'b1;
        set_cmd(0, 12'h050); req_valid = 4'b0001;
        wait_ready("bp grant", 4'b0001);
        step();
        req_valid = 4'b0100;
        wait_rsp("bp rsp");
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp hold %0d", c),
                {rsp_vec(), req_ready, alu_start, busy},
                {1'b1, 2'd0, 8'h05, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1});
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        wait_ready("bp next grant", 4'b0100);
        step();
        req_valid = '0;
        wait_rsp("bp req2 rsp");
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset while waiting on the ALU, then a clean transaction.
        respond = 1'b0; cas_in = 1'b0;
        set_cmd(0, 12'h050); req_valid = 4'b0001;
        wait_ready("rst grant", 4'b0001);
        step();
        step();
        chk("rst in wait busy", {busy, alu_cmd}, {1'b1, 12'h050});
        rst = 1'b1;
        #1;
        chk("rst outputs same cycle", all_out(), 31'd0);
        step();
        chk("rst held outputs", all_out(), 31'd0);
        rst = 1'b0; respond = 1'b1;
        wait_ready("post rst grant", 4'b0001);
        step();
        req_valid = '0;
        chk("post rst start", {alu_start, alu_cmd}, {1'b1, 12'h050});
        wait_rsp("post rst rsp");
        chk("post rst rsp fields", rsp_vec(), {1'b1, 2'd0, 8'h05, 1'b0, 1'b0});
        rsp_ready = 1'b1;
        step();
        chk("post rst idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
